// File: rtl/store_narrower.sv
// Store-side narrowing unit: truncates a register value to byte/half/word and writes it
// little-endian to a byte-wide memory port, flagging values the narrowing cannot represent.
module store_narrower #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WIDTH-1:0]      req_data,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ack,
  output logic                  done,
  output logic                  ovf,
  output logic                  err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            k_q, k_d;
  logic [1:0]            last_q, last_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;

  logic                  acc_err, acc_ovf;
  logic [1:0]            acc_last;
  logic [WIDTH-1:0]      sext8, sext16, sext32, zext8, zext16, zext32;

  // Re-extended views of the source; a mismatch means the narrowed value loses information.
  assign sext8  = WIDTH'($signed(req_data[7:0]));
  assign sext16 = WIDTH'($signed(req_data[15:0]));
  assign sext32 = WIDTH'($signed(req_data[31:0]));
  assign zext8  = WIDTH'(req_data[7:0]);
  assign zext16 = WIDTH'(req_data[15:0]);
  assign zext32 = WIDTH'(req_data[31:0]);

  always_comb begin
    acc_err  = 1'b0;
    acc_ovf  = 1'b0;
    acc_last = 2'd0;
    case (req_size)
      2'b00: begin
        acc_last = 2'd0;
        acc_ovf  = req_signed ? (req_data != sext8) : (req_data != zext8);
      end
      2'b01: begin
        acc_last = 2'd1;
        acc_err  = req_addr[0];
        acc_ovf  = req_signed ? (req_data != sext16) : (req_data != zext16);
      end
      2'b10: begin
        acc_last = 2'd3;
        acc_err  = |req_addr[1:0];
        acc_ovf  = req_signed ? (req_data != sext32) : (req_data != zext32);
      end
      default: acc_err = 1'b1;
    endcase
    if (acc_err) acc_ovf = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    k_d     = k_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          data_d  = req_data[31:0];
          addr_d  = req_addr;
          k_d     = 2'd0;
          last_d  = acc_last;
          ovf_d   = acc_ovf;
          err_d   = acc_err;
          state_d = acc_err ? StDone : StWrite;
        end
      end
      StWrite: begin
        if (mem_ack) begin
          if (k_q == last_q) begin
            k_d     = 2'd0;
            state_d = StDone;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      addr_q  <= '0;
      k_q     <= 2'd0;
      last_q  <= 2'd0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_we    = (state_q == StWrite);
  assign mem_addr  = addr_q + ADDR_WIDTH'(k_q);
  assign mem_wdata = data_q[{k_q, 3'b000} +: 8];
  assign done      = (state_q == StDone);
  assign ovf       = done & ovf_q;
  assign err       = done & err_q;

endmodule

// File: tb/tb_store_narrower.sv
// Directed bench for store_narrower: table of single stores with ack tied high,
// plus hand sequences for wait states and mid-transfer reset.
module tb_store_narrower;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        done;
  logic        ovf;
  logic        err;

  int total = 0;
  int bad   = 0;

  store_narrower #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .done       (done),
    .ovf        (ovf),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    int          nb;     // bytes expected on the port (0 for error)
    logic [31:0] bytes;  // expected bytes, byte j in bits [8j+7:8j]
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] d, input logic [31:0] a, input logic [1:0] s,
                       input logic sg);
    req_valid  = 1'b1;
    req_data   = d;
    req_addr   = a;
    req_size   = s;
    req_signed = sg;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".ready_before"}, 32'(req_ready), 32'd1);
    issue(v.data, v.addr, v.size, v.sgn);
    for (int j = 0; j < v.nb; j++) begin
      chk($sformatf("%s.we%0d", t, j), 32'(mem_we), 32'd1);
      chk($sformatf("%s.addr%0d", t, j), mem_addr, v.addr + 32'(j));
      chk($sformatf("%s.wdata%0d", t, j), 32'(mem_wdata), 32'(v.bytes[8*j +: 8]));
      chk($sformatf("%s.busy%0d", t, j), {30'd0, req_ready, done}, 32'd0);
      tick();
    end
    chk({t, ".done"}, 32'(done), 32'd1);
    chk({t, ".we_at_done"}, 32'(mem_we), 32'd0);
    chk({t, ".ovf"}, 32'(ovf), 32'(v.ovf));
    chk({t, ".err"}, 32'(err), 32'(v.err));
    tick();
    chk({t, ".ready_after"}, 32'(req_ready), 32'd1);
    chk({t, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'hFFFFFF80, 32'h00000100, 2'b00, 1'b1, 1, 32'h00000080, 1'b0, 1'b0};
    vecs[1]  = '{32'h00000180, 32'h00000010, 2'b00, 1'b1, 1, 32'h00000080, 1'b1, 1'b0};
    vecs[2]  = '{32'h00000180, 32'h00000011, 2'b00, 1'b0, 1, 32'h00000080, 1'b1, 1'b0};
    vecs[3]  = '{32'h000000FF, 32'h00000013, 2'b00, 1'b0, 1, 32'h000000FF, 1'b0, 1'b0};
    vecs[4]  = '{32'h000000FF, 32'h00000014, 2'b00, 1'b1, 1, 32'h000000FF, 1'b1, 1'b0};
    vecs[5]  = '{32'h12345678, 32'hFFFFFFFC, 2'b10, 1'b0, 4, 32'h12345678, 1'b0, 1'b0};
    vecs[6]  = '{32'hFFFF8000, 32'h00000040, 2'b01, 1'b1, 2, 32'h00008000, 1'b0, 1'b0};
    vecs[7]  = '{32'h00018000, 32'h00000042, 2'b01, 1'b0, 2, 32'h00008000, 1'b1, 1'b0};
    vecs[8]  = '{32'h00001234, 32'h00000001, 2'b01, 1'b0, 0, 32'h00000000, 1'b0, 1'b1};
    vecs[9]  = '{32'h00000012, 32'h00000000, 2'b11, 1'b0, 0, 32'h00000000, 1'b0, 1'b1};
    vecs[10] = '{32'h00000012, 32'h00000102, 2'b10, 1'b0, 0, 32'h00000000, 1'b0, 1'b1};
    vecs[11] = '{32'h80000000, 32'h00000200, 2'b10, 1'b1, 4, 32'h80000000, 1'b0, 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_data   = '0;
    req_addr   = '0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    mem_ack    = 1'b1;
    tick();
    tick();
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", 32'(mem_wdata), 32'd0);
    chk("rst.flags", {29'd0, done, ovf, err}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Half store with two wait states on byte 0.
    mem_ack = 1'b0;
    issue(32'h0000BEEF, 32'h00000202, 2'b01, 1'b0);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("wait.we%0d", w), 32'(mem_we), 32'd1);
      chk($sformatf("wait.addr%0d", w), mem_addr, 32'h00000202);
      chk($sformatf("wait.wdata%0d", w), 32'(mem_wdata), 32'h000000EF);
      if (w == 2) mem_ack = 1'b1;
      tick();
    end
    chk("wait.addr_b1", mem_addr, 32'h00000203);
    chk("wait.wdata_b1", 32'(mem_wdata), 32'h000000BE);
    tick();
    chk("wait.done", 32'(done), 32'd1);
    chk("wait.ovf", 32'(ovf), 32'd0);
    tick();

    // Reset while byte 2 of a word store is on the port.
    issue(32'hA1B2C3D4, 32'h00000300, 2'b10, 1'b0);
    tick();
    tick();
    chk("rstmid.addr_b2", mem_addr, 32'h00000302);
    chk("rstmid.wdata_b2", 32'(mem_wdata), 32'h000000B2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.we", 32'(mem_we), 32'd0);
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    chk("rstmid.done", 32'(done), 32'd0);
    tick();
    chk("rstmid.no_done", 32'(done), 32'd0);
    run_vec('{32'h0000005A, 32'h00000400, 2'b00, 1'b0, 1, 32'h0000005A, 1'b0, 1'b0}, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_narrower.md
# store_narrower

Store-side narrowing unit: the write-path counterpart of the sign/zero extenders on the load and immediate paths. It accepts a WIDTH-bit register value with an access size (byte/half/word) and writes the truncated value to an 8-bit memory port, one byte per cycle, little-endian. It flags values that the narrowing cannot represent, signed or unsigned, so that re-extending the stored value would not reproduce the source. It sits between the execute stage and the byte-wide data memory.

## Interface
- WIDTH, 32, register/data width; fixed multiple of 8, at least 32
- ADDR_WIDTH, 32, byte address width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept
- req_data  in  WIDTH  source register value
- req_addr  in  ADDR_WIDTH  byte address of the least-significant byte
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_signed  in  1  1 = signed overflow check, 0 = unsigned
- mem_we  out  1  byte write strobe
- mem_addr  out  ADDR_WIDTH  byte address
- mem_wdata  out  8  byte data
- mem_ack  in  1  memory accepts the byte this cycle when mem_we=1
- done  out  1  one-cycle completion pulse
- ovf  out  1  valid with done; value not representable in the access size
- err  out  1  valid with done; illegal size or misaligned address, nothing written

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture data, addr, size and signed, and compute n = 8, 16 or 32 bits and byte count N = 1, 2 or 4.
- Error check at accept:
  - size=11, half with addr[0]=1, or word with addr[1:0]≠00 sets err.
  - On error, go straight to DONE. No mem_we is issued, and ovf=0.
- Overflow at accept:
  - Signed: bits [WIDTH-1:n-1] are not all equal.
  - Unsigned: bits [WIDTH-1:n] are not all zero.
  - When n=WIDTH, ovf=0.
  - Overflow does not abort the store. The truncated value is still written.
- WRITE:
  - mem_we=1, mem_addr = addr + k, mem_wdata = data[8k+7:8k], with byte counter k starting at 0.
  - Outputs hold stable until mem_ack.
  - On mem_ack: k increments. When k = N-1, go to DONE.
- DONE:
  - done=1 for one cycle. ovf and err are valid this cycle only.
  - Go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Data bits above n are never written.
- req_valid while busy is ignored, because req_ready=0. The requester holds its request.
- mem_ack while mem_we=0 is ignored.

## Timing
- Reset values: state IDLE, req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, ovf=0, err=0, k=0.
- Accept at edge T: req_ready falls after T. mem_we=1 for byte 0 from T+1.
- With mem_ack tied high, one byte is written per cycle and byte N-1 is acked at cycle T+N.
  - done is at T+N+1.
  - req_ready is high again at T+N+2, so the next accept is at T+N+2.
- Error path: accept at T, done with err=1 at T+1, req_ready at T+2.
- Wait states: each cycle of mem_ack=0 extends the sequence by one cycle. mem_addr and mem_wdata must not change while waiting.
- rst mid-transfer:
  - On the next edge, return to IDLE and clear mem_we.
  - No done is issued for the abandoned store. Bytes already acked stay written.
- rst has priority over every other input on the same edge.

## Test plan
- Byte signed: data=0xFFFFFF80, addr=0x100, size=00, signed=1, ack tied 1 -> one write of 0x80 at 0x100; done at T+2 with ovf=0, err=0.
- Byte overflow, both modes:
  - data=0x00000180, size=00, signed=1 -> 0x80 written, ovf=1.
  - Same data with signed=0 -> ovf=1.
  - data=0x000000FF, signed=0 -> ovf=0.
- Half with wait states: data=0x0000BEEF, addr=0x202, size=01, signed=0, mem_ack low for 2 cycles on byte 0 -> 0xEF at 0x202 held 3 cycles, then 0xBE at 0x203; done at T+5 with ovf=0.
- Word wrap: data=0x12345678, addr=0xFFFFFFFC, size=10 -> bytes 78, 56, 34, 12 written to FC, FD, FE, FF; done at T+5; req_ready high at T+6.
- Errors:
  - Half at addr=0x001 -> no mem_we; done with err=1 at T+1.
  - size=11 -> same response.
- Reset during byte 2 of a word store -> mem_we=0 after the edge, no done, req_ready=1, and a following byte store completes normally.
